lector16bits_skid: RTL

LECTOR16BITS_SKID -- requirements
Module: lector16bits_skid

---
 rtl/lector16bits_skid.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lector16bits_skid.sv
// ----------------------------------------------------------------------------
// lector16bits_skid
//   Two-entry valid/ready buffer for 16-bit words: a main register that
//   drives Q, plus one skid register that absorbs a word while the consumer
//   stalls. IN_READY is a pure function of the occupancy state, so the
//   ready path from the consumer never reaches the producer combinationally.
//
//   Optional feature: define LECTOR_PARITY_EN to store an even-parity bit
//   with every entry (17-bit main/skid) and drive it on PAR alongside Q.
//   With the macro undefined, PAR and all parity storage are absent.
// ----------------------------------------------------------------------------
module lector16bits_skid #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] D,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic [1:0]  COUNT
`ifdef LECTOR_PARITY_EN
  ,
  output logic        PAR
`endif
);

  // Occupancy states; the encoding equals the number of stored words so
  // COUNT can be driven straight from the state register.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b10;

  // Width of one stored entry: data, plus a parity bit when enabled.
`ifdef LECTOR_PARITY_EN
  localparam int ENTRY_W = 17;
`else
  localparam int ENTRY_W = 16;
`endif

  logic [1:0]         state;
  logic [1:0]         state_nxt;

  logic               in_fire;
  logic               out_fire;
  logic               load_main;
  logic               load_skid;
  logic               main_from_skid;

  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;
  logic [ENTRY_W-1:0] d_entry;
  logic [ENTRY_W-1:0] reset_entry;

  // Entry formatting: parity bit (when present) sits above the data word.
`ifdef LECTOR_PARITY_EN
  assign d_entry     = {^D, D};
  assign reset_entry = {^RESET_VALUE, RESET_VALUE};
`else
  assign d_entry     = D;
  assign reset_entry = RESET_VALUE;
`endif

  // Handshake outputs decoded from the state register only.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case can leave it unassigned (latch).
    IN_READY  = 1'b1;
    OUT_VALID = 1'b0;
    COUNT     = 2'd0;
    unique case (state)
      S_EMPTY: begin
        IN_READY  = 1'b1;
        OUT_VALID = 1'b0;
        COUNT     = 2'd0;
      end
      S_ONE: begin
        IN_READY  = 1'b1;
        OUT_VALID = 1'b1;
        COUNT     = 2'd1;
      end
      S_FULL: begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b1;
        COUNT     = 2'd2;
      end
      default: begin
        // Unreachable encoding: present as empty and recover below.
        IN_READY  = 1'b1;
        OUT_VALID = 1'b0;
        COUNT     = 2'd0;
      end
    endcase
  end

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  // Next-state and register-load decisions for each occupancy state.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      S_EMPTY: begin
        // Without input, main keeps its last word so Q holds steady.
        if (in_fire) begin
          state_nxt = S_ONE;
          load_main = 1'b1;
        end
      end
      S_ONE: begin
        unique case ({in_fire, out_fire})
          2'b10: begin
            // Consumer stalled: park the new word behind the head.
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end
          2'b01: begin
            state_nxt = S_EMPTY;
          end
          2'b11: begin
            // Head leaves and new word replaces it in the same edge.
            state_nxt = S_ONE;
            load_main = 1'b1;
          end
          default: begin
            state_nxt = S_ONE;
          end
        endcase
      end
      S_FULL: begin
        // IN_READY is low here, so only the output side can move.
        if (out_fire) begin
          state_nxt      = S_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main and skid data registers.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: both data registers are reset, not just the state: Q is visible
    // while empty and must show RESET_VALUE, and the skid contents must not
    // leak a pre-reset word.
    if (RST) begin
      main_q <= reset_entry;
      skid_q <= reset_entry;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : d_entry;
      end
      if (load_skid) begin
        skid_q <= d_entry;
      end
    end
  end

  // Head-of-buffer outputs.
  assign Q = main_q[15:0];
`ifdef LECTOR_PARITY_EN
  assign PAR = main_q[16];
`endif

endmodule
